// File: rtl/hazard_pkg.sv
// Shared types and constants for the EX/MA multicycle-op stall controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } ch_state_t;

    localparam int unsigned CH_INPUT = 0;
    localparam int unsigned CH_SFPU  = 1;
    localparam int unsigned CH_LFPU  = 2;
    localparam int unsigned CH_CACHE = 3;

    // Bits needed to count 0..timeout-1; at least one bit.
    function automatic int unsigned tcnt_width(input int unsigned timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/mc_stall_chan.sv
// One tracked channel: IDLE/BUSY/DONE FSM, watchdog counter and sticky timeout flag.
module mc_stall_chan
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rstn,
    input  logic en,
    input  logic valid,
    input  logic others_stall,
    input  logic global_stall,
    input  logic err_clr,
    output logic req,
    output logic stall_ch,
    output logic busy,
    output logic timeout_err
);

    localparam int unsigned   TW      = tcnt_width(TIMEOUT_CYC);
    localparam bit            TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [TW-1:0] TO_LAST = TO_EN ? TW'(TIMEOUT_CYC - 1) : '0;

    ch_state_t     state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          err_q, err_d;
    logic          err_set;

    // Kept as plain assigns so the stall path never depends on others_stall.
    assign req         = (state_q == IDLE) & en;
    assign stall_ch    = req | ((state_q == BUSY) & ~valid);
    assign busy        = (state_q == BUSY);
    assign timeout_err = err_q;

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        err_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = BUSY;
                    tcnt_d  = '0;
                end
            end
            BUSY: begin
                if (valid) begin
                    // Park in DONE if another channel still holds the pipeline.
                    state_d = others_stall ? DONE : IDLE;
                end else if (TO_EN) begin
                    tcnt_d = tcnt_q + TW'(1);
                    if (tcnt_q == TO_LAST) begin
                        err_set = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (!global_stall) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = (err_q & ~err_clr) | err_set;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            tcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/mc_stall_ctrl.sv
// N-channel multicycle-op stall controller: stall/flush generation and stall-cycle counter.
module mc_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned TIMEOUT_CYC = 1024,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N_CH-1:0]  en_e,
    input  logic [N_CH-1:0]  valid,
    input  logic             pc_src_e,
    input  logic             err_clr,
    output logic [N_CH-1:0]  req_pulse,
    output logic [N_CH-1:0]  busy,
    output logic             stall,
    output logic             flush,
    output logic [N_CH-1:0]  timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [N_CH-1:0]  stall_vec;
    logic [N_CH-1:0]  others;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    assign stall     = |stall_vec;
    // A stalled branch waits: younger instructions have not moved yet.
    assign flush     = pc_src_e & ~stall;
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        others = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            for (int j = 0; j < int'(N_CH); j++) begin
                if (j != i) begin
                    others[i] = others[i] | stall_vec[j];
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_chan
        mc_stall_chan #(
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_chan (
            .clk          (clk),
            .rstn         (rstn),
            .en           (en_e[i]),
            .valid        (valid[i]),
            .others_stall (others[i]),
            .global_stall (stall),
            .err_clr      (err_clr),
            .req          (req_pulse[i]),
            .stall_ch     (stall_vec[i]),
            .busy         (busy[i]),
            .timeout_err  (timeout_err[i])
        );
    end

endmodule
